// File: rtl/adder_subtractor_seq.sv
// adder_subtractor_seq
// Multi-cycle N-bit adder/subtractor that walks the operands in W-bit slices,
// LSB first, keeping the carry (or inverted borrow) in a register between
// slices. Operations enter through a valid/ready input handshake and leave
// through a valid/ready output handshake; one operation is in flight at a time.
//
// Optional feature macro: SATURATE_EN
//   defined   -> on signed overflow Out[N-1:0] clamps to 0x7F..F / 0x80..0
//   undefined -> Out[N-1:0] is the wrapped result, no clamping logic exists
// Out[N] (carry/borrow) and Ovf always report the raw arithmetic.
//
// Handshake semantics (both sides): a transfer happens on a rising clk edge
// where valid and ready are both high. In_Ready is high only in IDLE;
// Out_Valid is high only in DONE and, once high, stays high with Out/Ovf
// frozen until the edge where Out_Ready is seen. Nothing is accepted on the
// same edge as an output transfer.
//
// dbg_state exposes the FSM state: 0 = IDLE, 1 = BUSY, 2 = DONE.

module adder_subtractor_seq #(
  parameter int N = 8,
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         In_Valid,
  output logic         In_Ready,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic         C_In,
  input  logic         Add_Sub,
  output logic         Out_Valid,
  input  logic         Out_Ready,
  output logic [N:0]   Out,
  output logic         Ovf,
  output logic [1:0]   dbg_state
);

  localparam int S  = N / W;
  localparam int CW = (S > 1) ? $clog2(S) : 1;
  localparam logic [CW-1:0] LAST_SLICE = CW'(S - 1);

  // Reject geometries that cannot be sliced evenly.
  generate
    if ((W < 1) || (W > N) || ((N % W) != 0)) begin : g_param_check
      $error("adder_subtractor_seq: N (%0d) must be a positive multiple of W (%0d)", N, W);
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state_q;
  state_t state_d;

  // FSM control strobes
  logic accept;
  logic step;
  logic last;

  // Operand / carry / result storage. a_q and b_q are shifted right one
  // slice per BUSY cycle so the current slice is always in bits [W-1:0].
  // b_q already holds ~B in subtract mode.
  logic [N-1:0]  a_q;
  logic [N-1:0]  b_q;
  logic [N-1:0]  res_q;
  logic          carry_q;
  logic          sub_q;
  logic [CW-1:0] cnt_q;

  // Current-slice arithmetic
  logic [W-1:0] a_s;
  logic [W-1:0] b_s;
  logic [W:0]   slice_full;
  logic [W-1:0] sum_s;
  logic         cout_s;
  logic         cmsb_s;
  logic         ovf_s;
  logic         carry_bit;
  logic [N-1:0] res_next;
  logic [N-1:0] res_final;

  assign dbg_state = state_q;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state, handshake outputs and datapath strobes
  always_comb begin
    state_d   = state_q;
    In_Ready  = 1'b0;
    Out_Valid = 1'b0;
    accept    = 1'b0;
    step      = 1'b0;
    last      = 1'b0;
    case (state_q)
      IDLE: begin
        In_Ready = 1'b1;
        if (In_Valid) begin
          accept  = 1'b1;
          state_d = BUSY;
        end
      end
      BUSY: begin
        step = 1'b1;
        if (cnt_q == LAST_SLICE) begin
          last    = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        Out_Valid = 1'b1;
        if (Out_Ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // One W-bit slice of A + B' + c. The carry into the slice MSB is recovered
  // from the sum bit, so on the top slice cmsb ^ cout is the signed overflow.
  assign a_s        = a_q[W-1:0];
  assign b_s        = b_q[W-1:0];
  assign slice_full = {1'b0, a_s} + {1'b0, b_s} + {{W{1'b0}}, carry_q};
  assign sum_s      = slice_full[W-1:0];
  assign cout_s     = slice_full[W];
  assign cmsb_s     = a_s[W-1] ^ b_s[W-1] ^ sum_s[W-1];
  assign ovf_s      = cmsb_s ^ cout_s;

  // Subtraction reports borrow, which is the inverted carry of A + ~B + ~c.
  assign carry_bit  = sub_q ? ~cout_s : cout_s;

  // New slice enters at the top of the result register and earlier slices
  // move down; after S steps slice k sits at bits [kW+W-1:kW].
  assign res_next   = (res_q >> W) | (N'(sum_s) << (N - W));

`ifdef SATURATE_EN
  // Clamp on overflow. Overflow only happens when A and B' share a sign,
  // so the MSB of A (top slice, bit W-1) gives the sign of the true result.
  always_comb begin
    res_final = res_next;
    if (ovf_s) begin
      res_final        = {N{~a_s[W-1]}};
      res_final[N-1]   = a_s[W-1];
    end
  end
`else
  assign res_final = res_next;
`endif

  // Operand capture, per-slice stepping and final result registration
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      sub_q   <= 1'b0;
      cnt_q   <= '0;
      Out     <= '0;
      Ovf     <= 1'b0;
    end else if (accept) begin
      a_q     <= A;
      b_q     <= Add_Sub ? ~B : B;
      carry_q <= Add_Sub ? ~C_In : C_In;
      sub_q   <= Add_Sub;
      cnt_q   <= '0;
      res_q   <= '0;
    end else if (step) begin
      a_q     <= a_q >> W;
      b_q     <= b_q >> W;
      carry_q <= cout_s;
      cnt_q   <= cnt_q + 1'b1;
      res_q   <= res_next;
      if (last) begin
        Out <= {carry_bit, res_final};
        Ovf <= ovf_s;
      end
    end
  end

  // Handshake invariants
  a_ready_valid_exclusive : assert property (
    @(posedge clk) disable iff (!rst_n) !(In_Ready && Out_Valid));

  a_done_holds : assert property (
    @(posedge clk) disable iff (!rst_n)
    (Out_Valid && !Out_Ready) |=> (Out_Valid && $stable(Out) && $stable(Ovf)));

  a_no_accept_after_handshake : assert property (
    @(posedge clk) disable iff (!rst_n)
    (Out_Valid && Out_Ready) |=> (In_Ready && !Out_Valid));

endmodule

// File: tb/tb_adder_subtractor_seq.sv
// Testbench for adder_subtractor_seq (N=8, W=4). Directed scenarios plus
// randomized operations, checked against an integer-arithmetic reference.
// Honours SATURATE_EN the same way the design does.

module tb_adder_subtractor_seq;

  localparam int N = 8;
  localparam int W = 4;
  localparam int S = N / W;

  // ---------------- clock / reset ----------------
  logic         clk = 1'b0;
  logic         rst_n;
  logic         In_Valid;
  logic         In_Ready;
  logic [N-1:0] A;
  logic [N-1:0] B;
  logic         C_In;
  logic         Add_Sub;
  logic         Out_Valid;
  logic         Out_Ready;
  logic [N:0]   Out;
  logic         Ovf;
  logic [1:0]   dbg_state;

  always #5 clk = ~clk;

  adder_subtractor_seq #(.N(N), .W(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .In_Valid  (In_Valid),
    .In_Ready  (In_Ready),
    .A         (A),
    .B         (B),
    .C_In      (C_In),
    .Add_Sub   (Add_Sub),
    .Out_Valid (Out_Valid),
    .Out_Ready (Out_Ready),
    .Out       (Out),
    .Ovf       (Ovf),
    .dbg_state (dbg_state)
  );

  // ---------------- scoreboard ----------------
  int         n_checks = 0;
  int         n_pass   = 0;
  logic [N:0] exp_q[$];
  logic       exp_ovf_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
  endtask

  // Reference: plain integer arithmetic. Returns {ovf, carry/borrow, result}.
  function automatic logic [N+1:0] model(input logic [N-1:0] a, input logic [N-1:0] b,
                                         input logic cin, input logic sub);
    int          ua;
    int          ub;
    int          sa;
    int          sb;
    int          ci;
    int          raw;
    int          sres;
    logic [31:0] rawbits;
    logic [N:0]  r;
    logic        ovf;
    logic [N-1:0] pos_lim;
    logic [N-1:0] neg_lim;
    ua = int'(a);
    ub = int'(b);
    sa = int'($signed(a));
    sb = int'($signed(b));
    ci = cin ? 1 : 0;
    if (!sub) begin
      raw     = ua + ub + ci;
      sres    = sa + sb + ci;
      rawbits = raw;
      r       = rawbits[N:0];
    end else begin
      raw        = ua - ub - ci;
      sres       = sa - sb - ci;
      rawbits    = raw;
      r[N-1:0]   = rawbits[N-1:0];
      r[N]       = (ua < ub + ci);
    end
    ovf = (sres > (1 << (N-1)) - 1) || (sres < -(1 << (N-1)));
    pos_lim = '1;
    pos_lim[N-1] = 1'b0;
    neg_lim = '0;
    neg_lim[N-1] = 1'b1;
`ifdef SATURATE_EN
    if (ovf) r[N-1:0] = (sres > 0) ? pos_lim : neg_lim;
`else
    if (ovf && (pos_lim == neg_lim)) r[N-1:0] = '0;
`endif
    return {ovf, r};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic push_expected(input logic [N-1:0] a, input logic [N-1:0] b,
                               input logic cin, input logic sub);
    logic [N+1:0] m;
    m = model(a, b, cin, sub);
    exp_q.push_back(m[N:0]);
    exp_ovf_q.push_back(m[N+1]);
  endtask

  // Present an operation at a negedge; returns at the negedge after acceptance.
  task automatic send(input logic [N-1:0] a, input logic [N-1:0] b,
                      input logic cin, input logic sub);
    int waited;
    waited = 0;
    while (!In_Ready && waited < 50) begin
      tick();
      waited++;
    end
    check("in_ready_before_send", In_Ready, 1);
    A = a; B = b; C_In = cin; Add_Sub = sub; In_Valid = 1'b1;
    tick();
    In_Valid = 1'b0;
    // Scramble inputs while BUSY; they must be ignored.
    A = N'($urandom); B = N'($urandom);
    C_In = 1'($urandom); Add_Sub = 1'($urandom);
    check("in_ready_after_accept", In_Ready, 0);
    push_expected(a, b, cin, sub);
  endtask

  task automatic wait_result();
    int lat;
    lat = 0;
    while (!Out_Valid && lat < 20) begin
      tick();
      lat++;
    end
    check("latency", lat, S);
  endtask

  task automatic recv(input int hold);
    logic [N:0] e;
    logic       eo;
    check("scoreboard_nonempty", exp_q.size() != 0, 1);
    e  = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
    eo = (exp_ovf_q.size() != 0) ? exp_ovf_q.pop_front() : 1'bx;
    check("out", Out, e);
    check("ovf", Ovf, eo);
    check("out_valid", Out_Valid, 1);
    repeat (hold) begin
      tick();
      check("hold_out", Out, e);
      check("hold_ovf", Ovf, eo);
      check("hold_out_valid", Out_Valid, 1);
      check("hold_in_ready", In_Ready, 0);
    end
    Out_Ready = 1'b1;
    tick();
    Out_Ready = 1'b0;
    check("post_hs_out_valid", Out_Valid, 0);
    check("post_hs_in_ready", In_Ready, 1);
    check("post_hs_out_held", Out, e);
  endtask

  task automatic directed(input string tag, input logic [N-1:0] a, input logic [N-1:0] b,
                          input logic cin, input logic sub,
                          input logic [N:0] spec_out, input logic spec_ovf);
    send(a, b, cin, sub);
    wait_result();
    check({tag, "_out"}, Out, spec_out);
    check({tag, "_ovf"}, Ovf, spec_ovf);
    recv(0);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    rst_n = 1'b0; In_Valid = 1'b0; Out_Ready = 1'b0;
    A = '0; B = '0; C_In = 1'b0; Add_Sub = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_in_ready", In_Ready, 1);
    check("rst_out_valid", Out_Valid, 0);
    check("rst_out", Out, 0);
    check("rst_ovf", Ovf, 0);
    rst_n = 1'b1;
    tick();

    // Spec vectors
`ifdef SATURATE_EN
    directed("add_5a_3c", 8'h5A, 8'h3C, 1'b0, 1'b0, 9'h07F, 1'b1);
`else
    directed("add_5a_3c", 8'h5A, 8'h3C, 1'b0, 1'b0, 9'h096, 1'b1);
`endif
    directed("add_ff_01_c1", 8'hFF, 8'h01, 1'b1, 1'b0, 9'h101, 1'b0);
    directed("sub_10_20", 8'h10, 8'h20, 1'b0, 1'b1, 9'h1F0, 1'b0);
`ifdef SATURATE_EN
    directed("sub_80_01_b1", 8'h80, 8'h01, 1'b1, 1'b1, 9'h080, 1'b1);
`else
    directed("sub_80_01_b1", 8'h80, 8'h01, 1'b1, 1'b1, 9'h07E, 1'b1);
`endif
    directed("sub_00_00_b1", 8'h00, 8'h00, 1'b1, 1'b1, 9'h1FF, 1'b0);

    // Extra boundary patterns checked against the model only
    send(8'h7F, 8'h00, 1'b1, 1'b0); wait_result(); recv(1);
    send(8'h00, 8'h80, 1'b0, 1'b1); wait_result(); recv(0);
    send(8'h80, 8'h80, 1'b0, 1'b0); wait_result(); recv(0);

    // Consumer stalls 5 cycles while a new operation is already offered
    send(8'h5A, 8'h3C, 1'b0, 1'b0);
    wait_result();
    A = 8'h33; B = 8'h11; C_In = 1'b1; Add_Sub = 1'b1; In_Valid = 1'b1;
    recv(5);
    tick();
    In_Valid = 1'b0;
    check("accept_after_hs", In_Ready, 0);
    push_expected(8'h33, 8'h11, 1'b1, 1'b1);
    wait_result();
    check("stalled_next_out", Out, 9'h021);
    recv(0);

    // Reset in the middle of an operation, after its first slice
    send(8'hFF, 8'h01, 1'b0, 1'b0);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_out_valid", Out_Valid, 0);
    check("midrst_in_ready", In_Ready, 1);
    check("midrst_out", Out, 0);
    check("midrst_ovf", Ovf, 0);
    exp_q.delete();
    exp_ovf_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("after_rst_out_valid", Out_Valid, 0);
    send(8'h01, 8'h02, 1'b0, 1'b0);
    wait_result();
    check("after_rst_out", Out, 9'h003);
    recv(0);

    // Randomized operations with random consumer stalls
    for (int i = 0; i < 40; i++) begin
      send(N'($urandom), N'($urandom), 1'($urandom), 1'($urandom));
      wait_result();
      recv($urandom_range(0, 3));
      if ($urandom_range(0, 1) == 1) tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
